hazard_ctrl_md: RTL and testbench

Parametrised successor to the P6 stall/forward unit for the 5-stage MIPS pipeline. Takes pre-decoded register addresses, Tuse and Tnew values from D/E/M/W rather than raw IR, and produces the stall signal and all forward-mux selects. Adds a sequential multiply/divide busy tracker, so HI/LO-dependent instructions in D stall while the MDU is busy. Also keeps a saturating stall-cycle counter for performance debug.

---
 rtl/hazard_ctrl_md_pkg.sv | 17 +
 rtl/hazard_ctrl_md_md_busy_ctr.sv | 34 +++
 rtl/hazard_ctrl_md.sv | 115 +++++++++++
 tb/tb_hazard_ctrl_md.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_md_pkg.sv
// Shared constants for the hazard/forward unit: forward-mux encodings and
// default multiply/divide latencies.
package hazard_ctrl_md_pkg;

  // Forward-mux select encodings, shared by every forward point.
  typedef enum logic [1:0] {
    FW_REG = 2'd0,
    FW_W   = 2'd1,
    FW_M   = 2'd2,
    FW_E   = 2'd3
  } fw_sel_e;

  // Cycles the MDU stays busy after the operation leaves E.
  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;

endpackage

// File: rtl/hazard_ctrl_md_md_busy_ctr.sv
// Multiply/divide busy tracker: a down-counter loaded when a mult/div sits
// in E, plus the combinational busy flag that also covers the start cycle.
module md_busy_ctr
  import hazard_ctrl_md_pkg::*;
#(
  parameter int CNT_W    = 4,
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  logic [CNT_W-1:0] md_cnt;

  // Load the latency on a start (restarting any operation in flight), else count down to 0.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      md_cnt <= '0;
    end else if (start) begin
      md_cnt <= is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - CNT_W'(1);
    end
  end

  // Busy during the start cycle and for every nonzero count after it.
  assign busy = start | (md_cnt != '0);

endmodule

// File: rtl/hazard_ctrl_md.sv
// Stall and forward control for the 5-stage MIPS pipeline, driven by
// pre-decoded addresses and Tuse/Tnew, with MDU busy stalls and a
// saturating stall-cycle counter.
module hazard_ctrl_md
  import hazard_ctrl_md_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int T_W         = 2,
  parameter int MULT_LAT    = MULT_LAT_DEF,
  parameter int DIV_LAT     = DIV_LAT_DEF,
  parameter int CNT_W       = 4,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [REG_AW-1:0]      d_a1,
  input  logic [REG_AW-1:0]      d_a2,
  input  logic [T_W-1:0]         d_rs_tuse,
  input  logic [T_W-1:0]         d_rt_tuse,
  input  logic                   d_md_use,
  input  logic [REG_AW-1:0]      e_a1,
  input  logic [REG_AW-1:0]      e_a2,
  input  logic [REG_AW-1:0]      e_a3,
  input  logic [T_W-1:0]         e_tnew,
  input  logic                   e_md_start,
  input  logic                   e_md_is_div,
  input  logic [REG_AW-1:0]      m_a2,
  input  logic [REG_AW-1:0]      m_a3,
  input  logic [T_W-1:0]         m_tnew,
  input  logic [REG_AW-1:0]      w_a3,
  input  logic                   stat_clr,
  output logic                   stall,
  output logic [1:0]             fw_d_rs,
  output logic [1:0]             fw_d_rt,
  output logic [1:0]             fw_e_rs,
  output logic [1:0]             fw_e_rt,
  output logic                   fw_m_rt,
  output logic                   md_busy,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  // A producer blocks a consumer when its value arrives later than needed.
  function automatic logic hazard(input logic [REG_AW-1:0] addr,
                                  input logic [T_W-1:0]    tuse,
                                  input logic [REG_AW-1:0] a3,
                                  input logic [T_W-1:0]    tnew);
    return (tnew > tuse) && (addr == a3) && (addr != '0);
  endfunction

  // A producer can forward once its result is ready (Tnew == 0); $0 is never forwarded.
  function automatic logic fw_hit(input logic [REG_AW-1:0] addr,
                                  input logic [REG_AW-1:0] a3,
                                  input logic [T_W-1:0]    tnew);
    return (tnew == '0) && (addr == a3) && (addr != '0);
  endfunction

  logic reg_stall;

  md_busy_ctr #(
    .CNT_W   (CNT_W),
    .MULT_LAT(MULT_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_md_busy_ctr (
    .clk   (clk),
    .reset (reset),
    .start (e_md_start),
    .is_div(e_md_is_div),
    .busy  (md_busy)
  );

  // Register hazards against E and M for both D operands; W is always ready.
  assign reg_stall = hazard(d_a1, d_rs_tuse, e_a3, e_tnew)
                   | hazard(d_a2, d_rt_tuse, e_a3, e_tnew)
                   | hazard(d_a1, d_rs_tuse, m_a3, m_tnew)
                   | hazard(d_a2, d_rt_tuse, m_a3, m_tnew);

  assign stall = reg_stall | (d_md_use & md_busy);

  // Forward selects with nearest-producer priority, independent of stall.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    fw_d_rs = FW_REG;
    fw_d_rt = FW_REG;
    fw_e_rs = FW_REG;
    fw_e_rt = FW_REG;

    if      (fw_hit(d_a1, e_a3, e_tnew)) fw_d_rs = FW_E;
    else if (fw_hit(d_a1, m_a3, m_tnew)) fw_d_rs = FW_M;
    else if (fw_hit(d_a1, w_a3, '0))     fw_d_rs = FW_W;

    if      (fw_hit(d_a2, e_a3, e_tnew)) fw_d_rt = FW_E;
    else if (fw_hit(d_a2, m_a3, m_tnew)) fw_d_rt = FW_M;
    else if (fw_hit(d_a2, w_a3, '0))     fw_d_rt = FW_W;

    if      (fw_hit(e_a1, m_a3, m_tnew)) fw_e_rs = FW_M;
    else if (fw_hit(e_a1, w_a3, '0))     fw_e_rs = FW_W;

    if      (fw_hit(e_a2, m_a3, m_tnew)) fw_e_rt = FW_M;
    else if (fw_hit(e_a2, w_a3, '0))     fw_e_rt = FW_W;
  end

  assign fw_m_rt = fw_hit(m_a2, w_a3, '0);

  // Stall statistics: clear wins, otherwise count stalled cycles up to all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stat_clr) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_md.sv
// Self-checking bench for hazard_ctrl_md: a table of combinational
// stall/forward vectors plus hand-written MDU and stall-counter sequences.
module tb_hazard_ctrl_md;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  d_a1, d_a2, e_a1, e_a2, e_a3, m_a2, m_a3, w_a3;
  logic [1:0]  d_rs_tuse, d_rt_tuse, e_tnew, m_tnew;
  logic        d_md_use, e_md_start, e_md_is_div, stat_clr;
  logic        stall, fw_m_rt, md_busy;
  logic [1:0]  fw_d_rs, fw_d_rt, fw_e_rs, fw_e_rt;
  logic [15:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_ctrl_md dut (
    .clk(clk), .reset(reset),
    .d_a1(d_a1), .d_a2(d_a2), .d_rs_tuse(d_rs_tuse), .d_rt_tuse(d_rt_tuse),
    .d_md_use(d_md_use),
    .e_a1(e_a1), .e_a2(e_a2), .e_a3(e_a3), .e_tnew(e_tnew),
    .e_md_start(e_md_start), .e_md_is_div(e_md_is_div),
    .m_a2(m_a2), .m_a3(m_a3), .m_tnew(m_tnew), .w_a3(w_a3),
    .stat_clr(stat_clr),
    .stall(stall), .fw_d_rs(fw_d_rs), .fw_d_rt(fw_d_rt),
    .fw_e_rs(fw_e_rs), .fw_e_rt(fw_e_rt), .fw_m_rt(fw_m_rt),
    .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic [4:0] d_a1, d_a2;
    logic [1:0] d_rs_tuse, d_rt_tuse;
    logic [4:0] e_a1, e_a2, e_a3;
    logic [1:0] e_tnew;
    logic [4:0] m_a2, m_a3;
    logic [1:0] m_tnew;
    logic [4:0] w_a3;
    logic       x_stall;
    logic [1:0] x_fdrs, x_fdrt, x_fers, x_fert;
    logic       x_fmrt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mkv(
    input logic [4:0] da1, da2, input logic [1:0] drs, drt,
    input logic [4:0] ea1, ea2, ea3, input logic [1:0] etn,
    input logic [4:0] ma2, ma3, input logic [1:0] mtn, input logic [4:0] wa3,
    input logic st, input logic [1:0] fdrs, fdrt, fers, fert, input logic fmrt);
    vec_t v;
    v.d_a1 = da1; v.d_a2 = da2; v.d_rs_tuse = drs; v.d_rt_tuse = drt;
    v.e_a1 = ea1; v.e_a2 = ea2; v.e_a3 = ea3; v.e_tnew = etn;
    v.m_a2 = ma2; v.m_a3 = ma3; v.m_tnew = mtn; v.w_a3 = wa3;
    v.x_stall = st; v.x_fdrs = fdrs; v.x_fdrt = fdrt;
    v.x_fers = fers; v.x_fert = fert; v.x_fmrt = fmrt;
    return v;
  endfunction

  task automatic bubbles();
    d_a1 = '0; d_a2 = '0; d_rs_tuse = 2'd3; d_rt_tuse = 2'd3; d_md_use = 1'b0;
    e_a1 = '0; e_a2 = '0; e_a3 = '0; e_tnew = '0;
    e_md_start = 1'b0; e_md_is_div = 1'b0;
    m_a2 = '0; m_a3 = '0; m_tnew = '0; w_a3 = '0; stat_clr = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic lw_hazard();
    e_a3 = 5'd8; e_tnew = 2'd2; d_a1 = 5'd8; d_rs_tuse = 2'd0;
  endtask

  // Issue one MDU op at the current negedge with d_md_use held, optionally
  // restarting as a div at cycle restart_at, and check stall/md_busy per cycle.
  task automatic md_run(input string tag, input logic is_div, input int busy_cycles,
                        input int restart_at, input int ncyc);
    d_md_use = 1'b1; e_md_start = 1'b1; e_md_is_div = is_div;
    for (int k = 0; k < ncyc; k++) begin
      if (k == restart_at) begin
        e_md_start = 1'b1; e_md_is_div = 1'b1;
      end
      #1;
      check($sformatf("%s_stall_c%0d", tag, k), stall, (k < busy_cycles));
      check($sformatf("%s_busy_c%0d", tag, k), md_busy, (k < busy_cycles));
      tick(1);
      e_md_start = 1'b0;
    end
    d_md_use = 1'b0;
  endtask

  initial begin
    bubbles();
    reset = 1'b1;
    tick(2);
    #1;
    check("rst_stall", stall, 1'b0);
    check("rst_md_busy", md_busy, 1'b0);
    check("rst_stall_cnt", stall_cnt, 16'd0);
    tick(1);
    reset = 1'b0;

    //          da1 da2 drs drt ea1 ea2 ea3 etn ma2 ma3 mtn wa3  st  fdrs fdrt fers fert fmrt
    vecs.push_back(mkv(0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0, 0, 0, 0)); // idle
    vecs.push_back(mkv(8, 0, 0, 3,  0, 0, 8, 2,  0, 0, 0, 0,   1, 0, 0, 0, 0, 0)); // lw -> beq
    vecs.push_back(mkv(0, 0, 3, 3,  9, 0, 0, 0,  0, 9, 0, 9,   0, 0, 0, 2, 0, 0)); // M beats W
    vecs.push_back(mkv(0, 0, 3, 3,  9, 0, 0, 0,  0, 0, 0, 9,   0, 0, 0, 1, 0, 0)); // W only
    vecs.push_back(mkv(6, 0, 0, 0,  6, 6, 0, 0,  6, 0, 0, 6,   0, 1, 0, 1, 1, 1)); // W to all
    vecs.push_back(mkv(5, 5, 0, 0,  0, 0, 5, 0,  0, 5, 0, 5,   0, 3, 3, 0, 0, 0)); // E beats M, W
    vecs.push_back(mkv(5, 0, 1, 3,  0, 0, 5, 1,  0, 5, 0, 0,   0, 2, 0, 0, 0, 0)); // tnew == tuse
    vecs.push_back(mkv(5, 0, 1, 3,  0, 0, 5, 2,  0, 5, 0, 0,   1, 2, 0, 0, 0, 0)); // tnew > tuse
    vecs.push_back(mkv(0, 7, 3, 0,  0, 0, 0, 0,  7, 7, 1, 7,   1, 0, 1, 0, 0, 1)); // M rt stall
    vecs.push_back(mkv(0, 0, 3, 3,  0,12, 0, 0,  0,12, 1,12,   0, 0, 0, 0, 1, 0)); // M not ready
    vecs.push_back(mkv(0, 0, 3, 3,  0,12, 0, 0,  0,12, 0,12,   0, 0, 0, 0, 2, 0)); // M ready
    vecs.push_back(mkv(4, 0, 0, 3,  0, 0, 3, 2,  0, 0, 0, 0,   0, 0, 0, 0, 0, 0)); // addr differs
    vecs.push_back(mkv(0, 0, 0, 0,  0, 0, 0, 2,  0, 0, 3, 0,   0, 0, 0, 0, 0, 0)); // $0 never
    vecs.push_back(mkv(10,0, 1, 3,  0, 0,10, 0,  0,10, 2, 0,   1, 3, 0, 0, 0, 0)); // M rs stall

    foreach (vecs[i]) begin
      tick(1);
      d_a1 = vecs[i].d_a1; d_a2 = vecs[i].d_a2;
      d_rs_tuse = vecs[i].d_rs_tuse; d_rt_tuse = vecs[i].d_rt_tuse;
      e_a1 = vecs[i].e_a1; e_a2 = vecs[i].e_a2; e_a3 = vecs[i].e_a3; e_tnew = vecs[i].e_tnew;
      m_a2 = vecs[i].m_a2; m_a3 = vecs[i].m_a3; m_tnew = vecs[i].m_tnew; w_a3 = vecs[i].w_a3;
      #1;
      check($sformatf("v%0d_stall", i),   stall,   vecs[i].x_stall);
      check($sformatf("v%0d_fw_d_rs", i), fw_d_rs, vecs[i].x_fdrs);
      check($sformatf("v%0d_fw_d_rt", i), fw_d_rt, vecs[i].x_fdrt);
      check($sformatf("v%0d_fw_e_rs", i), fw_e_rs, vecs[i].x_fers);
      check($sformatf("v%0d_fw_e_rt", i), fw_e_rt, vecs[i].x_fert);
      check($sformatf("v%0d_fw_m_rt", i), fw_m_rt, vecs[i].x_fmrt);
    end

    // Stall counter counts one per stalled cycle after a clear.
    tick(1);
    bubbles();
    stat_clr = 1'b1;
    tick(1);
    stat_clr = 1'b0;
    lw_hazard();
    #1;
    check("cnt_after_clr", stall_cnt, 16'd0);
    check("cnt_stall_on", stall, 1'b1);
    tick(3);
    #1;
    check("cnt_three", stall_cnt, 16'd3);

    // Mult: 1 + 5 busy cycles; div: 1 + 10; mult restarted as div at cycle 3.
    tick(1);
    bubbles();
    md_run("mult", 1'b0, 6, -1, 8);
    tick(2);
    md_run("div", 1'b1, 11, -1, 13);
    tick(2);
    md_run("rstrt", 1'b0, 14, 3, 16);

    // Div interrupted by reset at cycle 3: busy drops at once, counts cleared.
    tick(2);
    d_md_use = 1'b1; e_md_start = 1'b1; e_md_is_div = 1'b1;
    tick(1);
    e_md_start = 1'b0;
    tick(2);
    #1;
    check("divrst_busy_pre", md_busy, 1'b1);
    check("divrst_stall_pre", stall, 1'b1);
    reset = 1'b1;
    #1;
    check("divrst_busy", md_busy, 1'b0);
    check("divrst_stall", stall, 1'b0);
    check("divrst_cnt", stall_cnt, 16'd0);
    tick(1);
    reset = 1'b0;
    tick(1);
    #1;
    check("divrst_busy_after", md_busy, 1'b0);
    e_md_start = 1'b1;
    #1;
    check("divrst_busy_start", md_busy, 1'b1);
    tick(1);
    bubbles();

    // Saturation at all-ones, then clear wins over a live stall.
    stat_clr = 1'b1;
    tick(1);
    stat_clr = 1'b0;
    lw_hazard();
    tick(65536 + 5);
    #1;
    check("cnt_saturated", stall_cnt, 16'hFFFF);
    stat_clr = 1'b1;
    tick(1);
    #1;
    check("cnt_clr_priority", stall_cnt, 16'd0);
    stat_clr = 1'b0;
    tick(1);
    #1;
    check("cnt_after_sat_clr", stall_cnt, 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
